// File: rtl/verificador_pkg.sv
// rtl/verificador_pkg.sv - state encoding and width helpers for the password checker
package verificador_pkg;

    typedef enum logic [1:0] {
        ENTRADA,
        COMPARA,
        VITORIA,
        EXPLODIU
    } estado_t;

    function automatic int largura_idx(input int digitos);
        return (digitos > 1) ? $clog2(digitos) : 1;
    endfunction

    // Bits needed to hold any value in 0..valor_max.
    function automatic int largura_cont(input int valor_max);
        return (valor_max > 0) ? $clog2(valor_max + 1) : 1;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// rtl/detector_borda.sv - registered rising-edge detector with configurable reset level
module detector_borda #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulso
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign pulso = d & ~d_q;

endmodule

// File: rtl/verificador_senha.sv
// rtl/verificador_senha.sv - multi-digit password checker with attempt budget
// Optional mid-entry idle timeout enabled by defining VERIF_TIMEOUT_EN.
module verificador_senha
    import verificador_pkg::*;
#(
    parameter int WIDTH          = 7,
    parameter int DIGITS         = 4,
    parameter int MAX_TENTATIVAS = 3,
    parameter int TIMEOUT_CICLOS = 50000000
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    enter,
    input  logic                                    limpa,
    input  logic [WIDTH-1:0]                        tentativa,
    input  logic [DIGITS*WIDTH-1:0]                 senha,
    output logic                                    sinalvitoria,
    output logic                                    sinalerro,
    output logic                                    explodiu,
    output logic [largura_idx(DIGITS)-1:0]          digito_idx,
    output logic [largura_cont(MAX_TENTATIVAS)-1:0] tentativas_restantes
);

    localparam int IW = largura_idx(DIGITS);
    localparam int RW = largura_cont(MAX_TENTATIVAS);
    localparam logic [IW-1:0] IDX_ULTIMO   = IW'(DIGITS - 1);
    localparam logic [RW-1:0] RESTANTES_RST = RW'(MAX_TENTATIVAS);

    estado_t                    estado, estado_n;
    logic [DIGITS*WIDTH-1:0]    buffer, buffer_n;
    logic [IW-1:0]              idx_n;
    logic [RW-1:0]              rest_n;
    logic                       vit_n, erro_n, expl_n;
    logic                       pulso;
    logic                       senha_ok;

    detector_borda #(
        .RESET_VAL (1'b1)
    ) u_borda_enter (
        .clk   (clk),
        .reset (reset),
        .d     (enter),
        .pulso (pulso)
    );

`ifdef VERIF_TIMEOUT_EN
    localparam int TW = largura_cont(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

    logic [TW-1:0] timer, timer_n;
    logic          forca_erro, forca_erro_n;

    // A timed-out partial entry must fail regardless of what the buffer holds.
    assign senha_ok = (buffer == senha) && !forca_erro;
`else
    localparam int timeout_unused = TIMEOUT_CICLOS;

    assign senha_ok = (buffer == senha);
`endif

    always_comb begin
        estado_n = estado;
        buffer_n = buffer;
        idx_n    = digito_idx;
        vit_n    = sinalvitoria;
        erro_n   = 1'b0;
        expl_n   = explodiu;
        rest_n   = tentativas_restantes;
`ifdef VERIF_TIMEOUT_EN
        forca_erro_n = forca_erro;
        timer_n      = '0;
`endif
        case (estado)
            ENTRADA: begin
                if (limpa) begin
                    buffer_n = '0;
                    idx_n    = '0;
                end else if (pulso) begin
                    buffer_n[digito_idx*WIDTH +: WIDTH] = tentativa;
                    if (digito_idx == IDX_ULTIMO) begin
                        idx_n    = '0;
                        estado_n = COMPARA;
                    end else begin
                        idx_n = digito_idx + 1'b1;
                    end
                end
`ifdef VERIF_TIMEOUT_EN
                else if (digito_idx != '0) begin
                    if (timer == TIMER_MAX) begin
                        idx_n        = '0;
                        forca_erro_n = 1'b1;
                        estado_n     = COMPARA;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
`endif
            end
            COMPARA: begin
`ifdef VERIF_TIMEOUT_EN
                forca_erro_n = 1'b0;
`endif
                if (senha_ok) begin
                    vit_n    = 1'b1;
                    estado_n = VITORIA;
                end else begin
                    erro_n   = 1'b1;
                    rest_n   = tentativas_restantes - 1'b1;
                    buffer_n = '0;
                    if (tentativas_restantes == RW'(1)) begin
                        expl_n   = 1'b1;
                        estado_n = EXPLODIU;
                    end else begin
                        estado_n = ENTRADA;
                    end
                end
            end
            VITORIA:  estado_n = VITORIA;
            EXPLODIU: estado_n = EXPLODIU;
            default:  estado_n = ENTRADA;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado               <= ENTRADA;
            buffer               <= '0;
            digito_idx           <= '0;
            sinalvitoria         <= 1'b0;
            sinalerro            <= 1'b0;
            explodiu             <= 1'b0;
            tentativas_restantes <= RESTANTES_RST;
        end else begin
            estado               <= estado_n;
            buffer               <= buffer_n;
            digito_idx           <= idx_n;
            sinalvitoria         <= vit_n;
            sinalerro            <= erro_n;
            explodiu             <= expl_n;
            tentativas_restantes <= rest_n;
        end
    end

`ifdef VERIF_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer      <= '0;
            forca_erro <= 1'b0;
        end else begin
            timer      <= timer_n;
            forca_erro <= forca_erro_n;
        end
    end
`endif

endmodule

// File: tb/tb_verificador_senha.sv
// tb/tb_verificador_senha.sv - scoreboard bench for verificador_senha
module tb_verificador_senha;

    localparam int WIDTH = 7;
    localparam int DIGITS = 4;
    localparam int MAXT = 3;
    localparam int TOUT = 20;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enter;
    logic                    limpa;
    logic [WIDTH-1:0]        tentativa;
    logic [DIGITS*WIDTH-1:0] senha;
    logic                    sinalvitoria;
    logic                    sinalerro;
    logic                    explodiu;
    logic [1:0]              digito_idx;
    logic [1:0]              tentativas_restantes;

    typedef struct {
        string      tag;
        logic [1:0] idx;
        logic [1:0] rest;
        logic       vit;
        logic       err;
        logic       expl;
    } exp_t;

    exp_t fila[$];
    int   n_assert = 0;
    int   n_fail = 0;

    logic [WIDTH-1:0] m_buf [DIGITS];
    logic [WIDTH-1:0] senha_ref [DIGITS];
    int               m_idx;
    int               m_rest;
    logic             m_vit;
    logic             m_exp;
    int               seen_at;

    localparam logic [DIGITS*WIDTH-1:0] SENHA_OK = {7'd9, 7'd5, 7'd3, 7'd1};

    verificador_senha #(
        .WIDTH          (WIDTH),
        .DIGITS         (DIGITS),
        .MAX_TENTATIVAS (MAXT),
        .TIMEOUT_CICLOS (TOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .enter                (enter),
        .limpa                (limpa),
        .tentativa            (tentativa),
        .senha                (senha),
        .sinalvitoria         (sinalvitoria),
        .sinalerro            (sinalerro),
        .explodiu             (explodiu),
        .digito_idx           (digito_idx),
        .tentativas_restantes (tentativas_restantes)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset;
        m_idx = 0;
        m_rest = MAXT;
        m_vit = 1'b0;
        m_exp = 1'b0;
        foreach (m_buf[i]) m_buf[i] = '0;
    endtask

    task automatic push(input string tag, input logic err);
        exp_t e;
        e.tag = tag;
        e.idx = 2'(m_idx);
        e.rest = 2'(m_rest);
        e.vit = m_vit;
        e.err = err;
        e.expl = m_exp;
        fila.push_back(e);
    endtask

    task automatic model_fail;
        m_rest--;
        foreach (m_buf[i]) m_buf[i] = '0;
        if (m_rest == 0) m_exp = 1'b1;
    endtask

    task automatic model_digit(input logic [WIDTH-1:0] d, input string tag);
        logic err;
        logic ok;
        err = 1'b0;
        if (!(m_vit || m_exp)) begin
            m_buf[m_idx] = d;
            if (m_idx == DIGITS - 1) begin
                m_idx = 0;
                ok = 1'b1;
                for (int i = 0; i < DIGITS; i++)
                    if (m_buf[i] != senha_ref[i]) ok = 1'b0;
                if (ok) begin
                    m_vit = 1'b1;
                end else begin
                    err = 1'b1;
                    model_fail();
                end
            end else begin
                m_idx++;
            end
        end
        push(tag, err);
    endtask

    task automatic check_out;
        exp_t e;
        n_assert++;
        assert (fila.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
        end
        if (fila.size() != 0) begin
            e = fila.pop_front();
            chk({e.tag, "_idx"},  8'(digito_idx),           8'(e.idx));
            chk({e.tag, "_rest"}, 8'(tentativas_restantes), 8'(e.rest));
            chk({e.tag, "_vit"},  8'(sinalvitoria),         8'(e.vit));
            chk({e.tag, "_err"},  8'(sinalerro),            8'(e.err));
            chk({e.tag, "_expl"}, 8'(explodiu),             8'(e.expl));
        end
    endtask

    task automatic press(input logic [WIDTH-1:0] d, input string tag);
        model_digit(d, tag);
        tentativa = d;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        check_out();
    endtask

    task automatic do_reset;
        enter = 1'b0;
        limpa = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        model_reset();
    endtask

    initial begin
        senha_ref[0] = 7'd1;
        senha_ref[1] = 7'd3;
        senha_ref[2] = 7'd5;
        senha_ref[3] = 7'd9;
        senha = SENHA_OK;
        tentativa = '0;
        enter = 1'b0;
        limpa = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
        push("reset", 1'b0);
        tick();
        check_out();

        // Correct sequence, then an ignored entry in VITORIA
        press(7'd1, "vit_d0");
        press(7'd3, "vit_d1");
        press(7'd5, "vit_d2");
        press(7'd9, "vit_d3");
        tick();
        chk("vit_hold", 8'(sinalvitoria), 8'd1);
        chk("vit_no_err", 8'(sinalerro), 8'd0);
        press(7'd9, "vit_ignored");

        // Three wrong attempts exhaust the budget
        do_reset();
        for (int a = 0; a < MAXT; a++) begin
            press(7'd1, "bad_d0");
            press(7'd3, "bad_d1");
            press(7'd5, "bad_d2");
            press(7'd8, "bad_d3");
            tick();
            chk("err_one_cycle", 8'(sinalerro), 8'd0);
        end
        press(7'd1, "expl_ignored");
        chk("expl_no_vit", 8'(sinalvitoria), 8'd0);

        // Enter held high captures a single digit
        do_reset();
        model_digit(7'd1, "hold");
        tentativa = 7'd1;
        enter = 1'b1;
        repeat (10) tick();
        enter = 1'b0;
        tick();
        check_out();

        // limpa beats a simultaneous enter; senha only matters at compare
        do_reset();
        press(7'd1, "limpa_d0");
        press(7'd3, "limpa_d1");
        limpa = 1'b1;
        enter = 1'b1;
        tentativa = 7'd5;
        tick();
        limpa = 1'b0;
        enter = 1'b0;
        tick();
        m_idx = 0;
        foreach (m_buf[i]) m_buf[i] = '0;
        push("limpa", 1'b0);
        check_out();
        senha = '0;
        press(7'd1, "chg_d0");
        press(7'd3, "chg_d1");
        press(7'd5, "chg_d2");
        senha = SENHA_OK;
        press(7'd9, "chg_d3");

        // Asynchronous reset mid-entry with enter held through release
        do_reset();
        press(7'd1, "rst_d0");
        press(7'd3, "rst_d1");
        tentativa = 7'd5;
        enter = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        push("rst_async", 1'b0);
        check_out();
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        push("rst_enter_held", 1'b0);
        check_out();
        enter = 1'b0;
        tick();
        press(7'd5, "rst_after");

        // Idle mid-entry
        do_reset();
        press(7'd1, "idle_d0");
        seen_at = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (sinalerro === 1'b1) begin
                seen_at = c;
                break;
            end
        end
`ifdef VERIF_TIMEOUT_EN
        chk("timeout_cycle", 8'(seen_at), 8'd20);
        m_idx = 0;
        model_fail();
        push("timeout", 1'b1);
        check_out();
`else
        chk("no_timeout_err", 8'(seen_at), 8'hFF);
        push("no_timeout", 1'b0);
        check_out();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
